// File: rtl/ibex_vector_store_unit.sv
// ibex_vector_store_unit: reads one 128b VRF group and writes 1/2/4 of its words to memory, one bus write per word
module ibex_vector_store_unit #(
  parameter int VLEN   = 32,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [4:0]            vs_addr_i,
  input  logic [2:0]            vlmul_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [4:0]            vrf_raddr_o,
  input  logic [VLEN*NREGS-1:0] vrf_rdata_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_err_i,
  output logic [ADDR_W-1:0]     data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [VLEN-1:0]       data_wdata_o
);
  typedef enum logic [2:0] {IDLE, READ, REQ, WAIT, DONE} state_t;
  state_t                 r_state, w_next;
  logic [4:0]             r_vs;
  logic [1:0]             r_lmul;
  logic [ADDR_W-1:0]      r_base;
  logic [VLEN*NREGS-1:0]  r_buf;
  logic [1:0]             r_idx;
  logic                   r_err;
  logic                   w_bad;
  logic [1:0]             w_word, w_last;
  assign w_bad  = vlmul_i > 3'd2 || base_addr_i[1:0] != 2'b00;
  // position of the current register inside the 4-word group buffer
  assign w_word = r_lmul == 2'd0 ? r_vs[1:0] : r_lmul == 2'd1 ? {r_vs[1], r_idx[0]} : r_idx;
  assign w_last = r_lmul == 2'd0 ? 2'd0 : r_lmul == 2'd1 ? 2'd1 : 2'd3;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_next = w_bad ? DONE : READ;
      READ:    w_next = REQ;
      REQ:     if (data_gnt_i) w_next = WAIT;
      WAIT:    if (data_rvalid_i) w_next = (data_err_i || r_idx == w_last) ? DONE : REQ;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_vs    <= '0;
      r_lmul  <= '0;
      r_base  <= '0;
      r_buf   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start_i) begin
        r_vs   <= vs_addr_i;
        r_lmul <= vlmul_i[1:0];
        r_base <= base_addr_i;
        r_idx  <= '0;
        r_err  <= w_bad;
      end
      if (r_state == READ) r_buf <= vrf_rdata_i;
      if (r_state == WAIT && data_rvalid_i) begin
        r_err <= r_err | data_err_i;
        r_idx <= r_idx + 2'd1;
      end
    end
  end
  assign busy_o       = r_state inside {READ, REQ, WAIT};
  assign done_o       = r_state == DONE;
  assign err_o        = done_o & r_err;
  assign vrf_raddr_o  = r_state == READ ? {r_vs[4:2], 2'b00} : 5'd0;
  assign data_req_o   = r_state == REQ;
  assign data_we_o    = data_req_o;
  assign data_be_o    = {4{data_req_o}};
  assign data_addr_o  = data_req_o ? r_base + {{(ADDR_W-4){1'b0}}, r_idx, 2'b00} : '0;
  assign data_wdata_o = data_req_o ? r_buf[w_word*VLEN +: VLEN] : '0;
endmodule

// File: tb/tb_ibex_vector_store_unit.sv
// tb_ibex_vector_store_unit: randomized bus-slave bench with a register-group reference model
module tb_ibex_vector_store_unit;
  logic clk_i = 1'b0;
  logic rst_i, start_i;
  logic [4:0] vs_addr_i;
  logic [2:0] vlmul_i;
  logic [31:0] base_addr_i;
  logic busy_o, done_o, err_o;
  logic [4:0] vrf_raddr_o;
  logic [127:0] vrf_rdata_i;
  logic data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0] data_be_o;
  logic [31:0] vrf [32];
  logic [31:0] got_addr[$], got_data[$];
  int vectors = 0, miscompares = 0;

  ibex_vector_store_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .vs_addr_i(vs_addr_i),
    .vlmul_i(vlmul_i), .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .vrf_raddr_o(vrf_raddr_o), .vrf_rdata_i(vrf_rdata_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  assign vrf_rdata_i = {vrf[{vrf_raddr_o[4:2], 2'd3}], vrf[{vrf_raddr_o[4:2], 2'd2}],
                        vrf[{vrf_raddr_o[4:2], 2'd1}], vrf[{vrf_raddr_o[4:2], 2'd0}]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Drives one store and acts as the memory slave; every cycle is checked against the model.
  // gnt delay is drawn from [gmin,gmax]; gmax>0 also randomizes rvalid latency.
  task automatic run_txn(input logic [4:0] vs, input logic [2:0] lm, input logic [31:0] base,
                         input int err_pos, input int gmin, input int gmax, input int exp_cycle);
    int n, nw, k, c, gw;
    bit outst, exp_err, legal, done_seen;
    logic [31:0] ea[4], ed[4];
    legal = lm <= 3'd2 && base[1:0] == 2'b00;
    n = legal ? (1 << lm) : 0;
    for (int j = 0; j < n; j++) begin
      ea[j] = base + 32'(4 * j);
      ed[j] = vrf[(int'(vs) / n) * n + j];
    end
    exp_err = !legal || (err_pos >= 0 && err_pos < n);
    nw = (legal && err_pos >= 0 && err_pos < n) ? err_pos + 1 : n;
    got_addr.delete();
    got_data.delete();
    start_i = 1'b1; vs_addr_i = vs; vlmul_i = lm; base_addr_i = base;
    step();
    k = 0; gw = -1; outst = 1'b0; done_seen = 1'b0; c = 1;
    while (c < 300 && !done_seen) begin
      start_i = $urandom_range(3, 0) == 0;
      vs_addr_i = 5'($urandom); vlmul_i = 3'($urandom); base_addr_i = $urandom;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      chk("we_eq_req", 32'(data_we_o), 32'(data_req_o));
      chk("be", 32'(data_be_o), data_req_o ? 32'hF : 32'h0);
      if (c == 1 && legal) chk("vrf_raddr", 32'(vrf_raddr_o), 32'(vs & 5'h1C));
      if (done_o) begin
        done_seen = 1'b1;
        chk("busy_in_done", 32'(busy_o), 0);
        chk("err", 32'(err_o), 32'(exp_err));
        chk("nwrites", k, nw);
        if (exp_cycle > 0) chk("done_cycle", c, exp_cycle);
      end else begin
        chk("busy", 32'(busy_o), 1);
        chk("err_low", 32'(err_o), 0);
        if (outst) begin
          chk("req_in_wait", 32'(data_req_o), 0);
          if (gmax == 0 || $urandom_range(2, 0) != 0) begin
            data_rvalid_i = 1'b1;
            data_err_i = (k - 1 == err_pos);
            outst = 1'b0;
          end
        end else begin
          data_rvalid_i = $urandom_range(3, 0) == 0;
          data_err_i = 1'($urandom);
          if (data_req_o) begin
            if (k >= nw) chk("extra_req", k, nw);
            else begin
              chk("addr", data_addr_o, ea[k]);
              chk("wdata", data_wdata_o, ed[k]);
            end
            if (gw < 0) gw = $urandom_range(gmax, gmin);
            if (gw == 0) begin
              data_gnt_i = 1'b1;
              got_addr.push_back(data_addr_o);
              got_data.push_back(data_wdata_o);
              k++;
              outst = 1'b1;
              gw = -1;
            end else gw--;
          end else if (gw >= 0) chk("req_held", 32'(data_req_o), 1);
        end
        step();
        c++;
      end
    end
    if (!done_seen) chk("timeout", 0, 1);
    step();
    start_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done", 32'(done_o), 0);
    chk("idle_req", 32'(data_req_o), 0);
  endtask

  initial begin
    int cyc;
    logic [31:0] b;
    rst_i = 1'b1; start_i = 1'b0; vs_addr_i = '0; vlmul_i = '0; base_addr_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    for (int i = 0; i < 32; i++) vrf[i] = $urandom;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_req", 32'(data_req_o), 0);
    chk("rst_we", 32'(data_we_o), 0);
    chk("rst_be", 32'(data_be_o), 0);
    chk("rst_addr", data_addr_o, 0);
    chk("rst_wdata", data_wdata_o, 0);
    chk("rst_raddr", 32'(vrf_raddr_o), 0);
    rst_i = 1'b0;
    vrf[6] = 32'hDEADBEEF;
    run_txn(5'd6, 3'b000, 32'h100, -1, 0, 0, 4);
    chk("t1_addr", got_addr.size() > 0 ? got_addr[0] : 32'hX, 32'h100);
    chk("t1_data", got_data.size() > 0 ? got_data[0] : 32'hX, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) vrf[8 + i] = 32'(i + 1);
    run_txn(5'd8, 3'b010, 32'h2000, -1, 0, 0, 10);
    chk("t2_cnt", got_addr.size(), 4);
    chk("t2_addr3", got_addr.size() == 4 ? got_addr[3] : 32'hX, 32'h200C);
    chk("t2_data0", got_data.size() == 4 ? got_data[0] : 32'hX, 32'h1);
    chk("t2_data3", got_data.size() == 4 ? got_data[3] : 32'hX, 32'h4);
    vrf[2] = 32'hA5A50002;
    vrf[3] = 32'hA5A50003;
    run_txn(5'd2, 3'b001, 32'h3000, -1, 3, 3, 0);
    chk("t3_data1", got_data.size() == 2 ? got_data[1] : 32'hX, 32'hA5A50003);
    chk("t3_addr1", got_addr.size() == 2 ? got_addr[1] : 32'hX, 32'h3004);
    run_txn(5'd4, 3'b011, 32'h100, -1, 0, 0, 1);
    run_txn(5'd4, 3'b000, 32'h102, -1, 0, 0, 1);
    run_txn(5'd16, 3'b010, 32'h400, 1, 0, 0, 6);
    chk("t6_cnt", got_addr.size(), 2);
    run_txn(5'd20, 3'b001, 32'hFFFFFFFC, -1, 0, 0, 6);
    chk("t7_addr0", got_addr.size() == 2 ? got_addr[0] : 32'hX, 32'hFFFFFFFC);
    chk("t7_addr1", got_addr.size() == 2 ? got_addr[1] : 32'hX, 32'h0);
    // reset while a write is outstanding
    start_i = 1'b1; vs_addr_i = 5'd12; vlmul_i = 3'b010; base_addr_i = 32'h40;
    step();
    start_i = 1'b0;
    cyc = 0;
    while (!data_req_o && cyc < 20) begin step(); cyc++; end
    chk("rst_mid_req_seen", 32'(data_req_o), 1);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    data_rvalid_i = 1'b1;
    chk("rst_mid_req", 32'(data_req_o), 0);
    chk("rst_mid_busy", 32'(busy_o), 0);
    chk("rst_mid_done", 32'(done_o), 0);
    step();
    data_rvalid_i = 1'b0;
    chk("late_rvalid_busy", 32'(busy_o), 0);
    chk("late_rvalid_req", 32'(data_req_o), 0);
    run_txn(5'd13, 3'b010, 32'h80, -1, 0, 0, 10);
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0) for (int i = 0; i < 32; i++) vrf[i] = $urandom;
      b = $urandom_range(7, 0) == 0 ? $urandom : ($urandom_range(3, 0) == 0 ? 32'hFFFFFFF0 : $urandom) & ~32'h3;
      if ($urandom_range(7, 0) == 0) b = 32'hFFFFFFF8 | 32'(2'($urandom) << 2);
      run_txn(5'($urandom), 3'($urandom_range(4, 0)), b,
              $urandom_range(3, 0) == 0 ? int'($urandom_range(3, 0)) : -1, 0, 3, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
